// File: rtl/wrd_mac_pkg.sv
// Shared definitions for the streaming multiply-accumulate block.
// This package holds the FSM encoding, the default widths, and the round and saturate helpers.
package wrd_mac_pkg;

  localparam int unsigned DEF_I_BW        = 8;
  localparam int unsigned DEF_BIAS_BW     = 2 * DEF_I_BW;
  localparam int unsigned DEF_ACC_BW      = 3 * DEF_I_BW;
  localparam int unsigned DEF_O_BW        = 3 * DEF_I_BW;
  localparam int unsigned DEF_NUM_CLASSES = 3;
  localparam int unsigned DEF_SHIFT       = 0;
  localparam int unsigned DEF_SATURATE    = 1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Round half up, then arithmetic shift. The sum wraps to 'width' bits before the shift.
  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                       input int unsigned shift,
                                                       input int unsigned width);
    logic signed [63:0] t;
    t = v;
    if (shift > 0) t = t + (64'sd1 <<< (shift - 1));
    t = (t <<< (64 - width)) >>> (64 - width);
    return t >>> shift;
  endfunction

  // Clamp to the signed range of an o_bw-bit value.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int unsigned o_bw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (o_bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One lane of the MAC datapath. It multiplies on a fired beat, accumulates, adds the bias captured from the last beat,
// rounds, saturates, and registers the result.
module mac_lane
  import wrd_mac_pkg::*;
#(
  parameter int unsigned I_BW     = DEF_I_BW,
  parameter int unsigned BIAS_BW  = 2 * I_BW,
  parameter int unsigned ACC_BW   = 3 * I_BW,
  parameter int unsigned O_BW     = 3 * I_BW,
  parameter int unsigned SHIFT    = DEF_SHIFT,
  parameter int unsigned SATURATE = DEF_SATURATE
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fire,
  input  logic               i_last,
  input  logic               i_load,
  input  logic [I_BW-1:0]    i_x,
  input  logic [I_BW-1:0]    i_w,
  input  logic [BIAS_BW-1:0] i_b,
  output logic [O_BW-1:0]    o_data
);

  logic signed [I_BW-1:0]    w_x;
  logic signed [I_BW-1:0]    w_w;
  logic signed [2*I_BW-1:0]  w_prod;
  logic signed [63:0]        w_sum;
  logic signed [63:0]        w_rnd;
  logic signed [O_BW-1:0]    w_out;

  logic signed [2*I_BW-1:0]  r_prod;
  logic signed [ACC_BW-1:0]  r_acc;
  logic signed [BIAS_BW-1:0] r_bias;
  logic signed [O_BW-1:0]    r_data;

  assign w_x    = i_x;
  assign w_w    = i_w;
  assign w_prod = (2*I_BW)'(w_x) * (2*I_BW)'(w_w);

  // acc + bias cannot overflow ACC_BW+1 bits, and the rounding constant wraps there too.
  assign w_sum = 64'(r_acc) + 64'(r_bias);
  assign w_rnd = round_half_up(w_sum, SHIFT, ACC_BW + 1);
  assign w_out = (SATURATE != 0) ? O_BW'(sat_to_width(w_rnd, O_BW)) : O_BW'(w_rnd);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prod <= '0;
      r_acc  <= '0;
      r_bias <= '0;
      r_data <= '0;
    end else begin
      r_prod <= i_fire ? w_prod : '0;
      r_acc  <= i_load ? '0 : r_acc + ACC_BW'(r_prod);
      if (i_fire && i_last) r_bias <= i_b;
      if (i_load)           r_data <= w_out;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mac_stream.sv
// Streaming MAC with NUM_CLASSES parallel lanes. The module joins the activation and parameter streams,
// then drains the pipeline and holds each packet result until downstream accepts it.
module mac_stream
  import wrd_mac_pkg::*;
#(
  parameter int unsigned I_BW        = DEF_I_BW,
  parameter int unsigned BIAS_BW     = 2 * I_BW,
  parameter int unsigned ACC_BW      = 3 * I_BW,
  parameter int unsigned O_BW        = 3 * I_BW,
  parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int unsigned SHIFT       = DEF_SHIFT,
  parameter int unsigned SATURATE    = DEF_SATURATE
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [NUM_CLASSES*I_BW-1:0]    data0_i,
  input  logic                           valid0_i,
  input  logic                           last0_i,
  output logic                           ready0_o,
  input  logic [NUM_CLASSES*I_BW-1:0]    data1_w_i,
  input  logic [NUM_CLASSES*BIAS_BW-1:0] data1_b_i,
  input  logic                           valid1_i,
  input  logic                           last1_i,
  output logic                           ready1_o,
  output logic [NUM_CLASSES*O_BW-1:0]    data_o,
  output logic                           valid_o,
  output logic                           last_o,
  input  logic                           ready_i,
  output logic                           err_o
);

  state_t r_state;
  logic   r_drain_cnt;
  logic   r_valid;
  logic   r_err;

  logic   w_accept;
  logic   w_fire;
  logic   w_last;
  logic   w_load;

  // Gating with reset keeps both readies low and blocks any beat while reset is held.
  assign w_accept = rst_n_i && (r_state == ACCUM);
  assign w_fire   = valid0_i && valid1_i && w_accept;
  assign w_last   = last0_i || last1_i;
  assign w_load   = (r_state == DRAIN) && r_drain_cnt;

  assign ready0_o = valid1_i && w_accept;
  assign ready1_o = valid0_i && w_accept;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= ACCUM;
      r_drain_cnt <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_fire && (last0_i != last1_i)) r_err <= 1'b1;
      case (r_state)
        ACCUM: begin
          if (w_fire && w_last) begin
            r_state     <= DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        // Two drain cycles let the last product reach the accumulator before the output loads.
        DRAIN: begin
          if (r_drain_cnt) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
          end else begin
            r_drain_cnt <= 1'b1;
          end
        end
        HOLD: begin
          if (ready_i) begin
            r_state <= ACCUM;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign valid_o = r_valid;
  assign last_o  = r_valid;
  assign err_o   = r_err;

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_lane
    mac_lane #(
      .I_BW    (I_BW),
      .BIAS_BW (BIAS_BW),
      .ACC_BW  (ACC_BW),
      .O_BW    (O_BW),
      .SHIFT   (SHIFT),
      .SATURATE(SATURATE)
    ) u_lane (
      .i_clk  (clk_i),
      .i_rst_n(rst_n_i),
      .i_fire (w_fire),
      .i_last (w_last),
      .i_load (w_load),
      .i_x    (data0_i[g*I_BW +: I_BW]),
      .i_w    (data1_w_i[g*I_BW +: I_BW]),
      .i_b    (data1_b_i[g*BIAS_BW +: BIAS_BW]),
      .o_data (data_o[g*O_BW +: O_BW])
    );
  end

endmodule
